// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment hex display controller: live, latched, counting and
// blinking modes, leading-zero blanking, registered active-low segment outputs.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [4*NUM_DIGITS-1:0] DATA_IN,
    input  logic                    LOAD,
    input  logic [1:0]              MODE,
    input  logic                    BLANK_LZ,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic                    TICK
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_LIVE  = 2'b00,
        MODE_LATCH = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_BLINK = 2'b11
    } mode_t;

    logic [DW-1:0]           div;
    logic                    wrap;
    logic                    blink;
    logic [4*NUM_DIGITS-1:0] value_next;
    logic [7*NUM_DIGITS-1:0] hex_next;
    logic                    all_zero;
    mode_t                   mode;

    assign mode = mode_t'(MODE);
    assign wrap = (div == DW'(TICK_DIV - 1));

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // LOAD always wins over the counting step, so a load on a wrap cycle is not incremented.
    always_comb begin
        value_next = VALUE;
        unique case (mode)
            MODE_LIVE:  value_next = DATA_IN;
            MODE_LATCH,
            MODE_BLINK: if (LOAD) value_next = DATA_IN;
            MODE_COUNT: begin
                if (LOAD)      value_next = DATA_IN;
                else if (wrap) value_next = VALUE + (4*NUM_DIGITS)'(1);
            end
        endcase
    end

    // Walk from the top digit down; all_zero stays set while every nibble so far is zero.
    always_comb begin
        hex_next = '1;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (VALUE[4*i +: 4] == 4'h0);
            hex_next[7*i +: 7] = seg7(VALUE[4*i +: 4]);
            if (BLANK_LZ && all_zero && (i != 0))
                hex_next[7*i +: 7] = 7'h7F;
            if ((mode == MODE_BLINK) && !blink)
                hex_next[7*i +: 7] = 7'h7F;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            div   <= '0;
            blink <= 1'b1;
            TICK  <= 1'b0;
            VALUE <= '0;
            HEX   <= '1;
        end else begin
            div   <= wrap ? '0 : div + DW'(1);
            if (wrap) blink <= ~blink;
            TICK  <= wrap;
            VALUE <= value_next;
            HEX   <= hex_next;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (4 digits, tick every 4 cycles): directed scenarios
// plus randomized traffic compared against a cycle-count based reference model.
module tb_hex_display_ctrl;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam logic [27:0] ALL_OFF = {4{7'h7F}};

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [15:0] DATA_IN  = '0;
    logic        LOAD     = 1'b0;
    logic [1:0]  MODE     = 2'b00;
    logic        BLANK_LZ = 1'b0;
    logic [27:0] HEX;
    logic [15:0] VALUE;
    logic        TICK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_cnt counts edges since the last reset edge.
    logic [15:0] m_val;
    int          m_cnt;
    logic [27:0] m_hex;
    logic        m_tick;
    logic [15:0] exp_q[$];

    hex_display_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .LOAD(LOAD),
        .MODE(MODE), .BLANK_LZ(BLANK_LZ), .HEX(HEX), .VALUE(VALUE), .TICK(TICK)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [27:0] render(input logic [15:0] v, input bit vis,
                                           input logic [1:0] mode, input logic blz);
        logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        logic [27:0] r;
        int msd;
        msd = 0;
        r = '0;
        for (int i = 0; i < ND; i++)
            if (v[4*i +: 4] != 4'h0) msd = i;
        for (int i = 0; i < ND; i++) begin
            if (mode == 2'b11 && !vis)  r[7*i +: 7] = 7'h7F;
            else if (blz && i > msd)    r[7*i +: 7] = 7'h7F;
            else                        r[7*i +: 7] = glyph[v[4*i +: 4]];
        end
        return r;
    endfunction

    task automatic cycle();
        bit wrap;
        @(posedge CLOCK_50);
        if (!RESET_N) begin
            m_val = '0; m_cnt = 0; m_hex = ALL_OFF; m_tick = 1'b0;
        end else begin
            wrap   = (m_cnt % TD) == TD - 1;
            m_hex  = render(m_val, ((m_cnt / TD) % 2) == 0, MODE, BLANK_LZ);
            m_tick = wrap;
            case (MODE)
                2'b00: m_val = DATA_IN;
                2'b10: if (LOAD) m_val = DATA_IN; else if (wrap) m_val = 16'(m_val + 1);
                default: if (LOAD) m_val = DATA_IN;
            endcase
            m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; LOAD = 1'b1; DATA_IN = 16'hABCD; MODE = 2'b01;
        cycle(); cycle();
        n_tests++; if (VALUE !== 16'h0) begin n_fail++; $display("FAIL reset_value: got %h exp 0000", VALUE); end
        n_tests++; if (HEX !== ALL_OFF) begin n_fail++; $display("FAIL reset_hex: got %h exp %h", HEX, ALL_OFF); end
        n_tests++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b exp 0", TICK); end
        RESET_N = 1'b1; LOAD = 1'b0; DATA_IN = '0; MODE = 2'b00; BLANK_LZ = 1'b1;
        cycle();
        n_tests++;
        if (HEX !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
            n_fail++; $display("FAIL release_hex: got %h exp %h", HEX, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        end
    endtask

    task automatic test_live();
        MODE = 2'b00; BLANK_LZ = 1'b0; DATA_IN = 16'h12AF;
        cycle(); cycle();
        n_tests++;
        if (HEX !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin
            n_fail++; $display("FAIL live_hex: got %h exp %h", HEX, {7'h79, 7'h24, 7'h08, 7'h0E});
        end
        n_tests++; if (VALUE !== 16'h12AF) begin n_fail++; $display("FAIL live_value: got %h exp 12af", VALUE); end
    endtask

    task automatic test_latched();
        MODE = 2'b01; BLANK_LZ = 1'b1; LOAD = 1'b1; DATA_IN = 16'h0030;
        cycle();
        LOAD = 1'b0; DATA_IN = 16'($urandom_range(16'h0100, 16'hFFFF));
        cycle(); cycle();
        n_tests++; if (VALUE !== 16'h0030) begin n_fail++; $display("FAIL latch_value: got %h exp 0030", VALUE); end
        n_tests++;
        if (HEX !== {7'h7F, 7'h7F, 7'h30, 7'h40}) begin
            n_fail++; $display("FAIL latch_hex: got %h exp %h", HEX, {7'h7F, 7'h7F, 7'h30, 7'h40});
        end
    endtask

    task automatic test_counter();
        int last_tick;
        RESET_N = 1'b0; cycle();
        RESET_N = 1'b1; MODE = 2'b10; BLANK_LZ = 1'b0; LOAD = 1'b1; DATA_IN = 16'hFFFE;
        cycle();
        LOAD = 1'b0;
        n_tests++; if (VALUE !== 16'hFFFE) begin n_fail++; $display("FAIL count_load: got %h exp fffe", VALUE); end
        exp_q = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        last_tick = -1;
        for (int k = 2; k < 20; k++) begin
            cycle();
            n_tests++; if (HEX !== m_hex) begin n_fail++; $display("FAIL count_hex: got %h exp %h", HEX, m_hex); end
            if (TICK === 1'b1) begin
                if (last_tick >= 0) begin
                    n_tests++;
                    if (k - last_tick != 4) begin n_fail++; $display("FAIL tick_spacing: got %0d exp 4", k - last_tick); end
                end
                last_tick = k;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL count_extra_tick: got tick exp none");
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (VALUE !== e) begin n_fail++; $display("FAIL count_step: got %h exp %h", VALUE, e); end
                end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL count_ticks: got %0d missing exp 0", exp_q.size()); end
    endtask

    task automatic test_load_wrap();
        MODE = 2'b10;
        for (int k = 0; k < 8 && (m_cnt % TD) != TD - 1; k++) cycle();
        LOAD = 1'b1; DATA_IN = 16'h0005;
        cycle();
        LOAD = 1'b0;
        n_tests++; if (VALUE !== 16'h0005) begin n_fail++; $display("FAIL load_wrap_value: got %h exp 0005", VALUE); end
        n_tests++; if (TICK !== 1'b1) begin n_fail++; $display("FAIL load_wrap_tick: got %b exp 1", TICK); end
    endtask

    task automatic test_blink();
        int vis, off;
        vis = 0; off = 0;
        RESET_N = 1'b0; cycle();
        RESET_N = 1'b1; MODE = 2'b11; BLANK_LZ = 1'b0; LOAD = 1'b1; DATA_IN = 16'h8888;
        cycle();
        LOAD = 1'b0;
        for (int k = 2; k < 18; k++) begin
            cycle();
            n_tests++; if (HEX !== m_hex) begin n_fail++; $display("FAIL blink_hex: got %h exp %h", HEX, m_hex); end
            if (HEX === 28'h0) vis++;
            else if (HEX === ALL_OFF) off++;
        end
        n_tests++; if (vis != 8 || off != 8) begin n_fail++; $display("FAIL blink_split: got %0d/%0d exp 8/8", vis, off); end
    endtask

    task automatic test_reset_mid();
        int n;
        MODE = 2'b10; LOAD = 1'b0;
        repeat ($urandom_range(1, 7)) cycle();
        RESET_N = 1'b0; LOAD = 1'b1; DATA_IN = 16'($urandom);
        cycle();
        n_tests++; if (VALUE !== 16'h0) begin n_fail++; $display("FAIL midreset_value: got %h exp 0000", VALUE); end
        n_tests++; if (HEX !== ALL_OFF) begin n_fail++; $display("FAIL midreset_hex: got %h exp %h", HEX, ALL_OFF); end
        n_tests++; if (TICK !== 1'b0) begin n_fail++; $display("FAIL midreset_tick: got %b exp 0", TICK); end
        RESET_N = 1'b1; LOAD = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(); n++;
            if (TICK === 1'b1) break;
        end
        n_tests++; if (TICK !== 1'b1 || n != 4) begin n_fail++; $display("FAIL midreset_first_tick: got %0d cycles exp 4", n); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            MODE     = 2'($urandom_range(0, 3));
            LOAD     = ($urandom_range(0, 3) == 0);
            BLANK_LZ = 1'($urandom);
            DATA_IN  = 16'($urandom >> $urandom_range(16, 31));
            RESET_N  = ($urandom_range(0, 49) != 0);
            cycle();
            n_tests++; if (HEX !== m_hex) begin n_fail++; $display("FAIL rand_hex: got %h exp %h", HEX, m_hex); end
            n_tests++; if (VALUE !== m_val) begin n_fail++; $display("FAIL rand_value: got %h exp %h", VALUE, m_val); end
            n_tests++; if (TICK !== m_tick) begin n_fail++; $display("FAIL rand_tick: got %b exp %b", TICK, m_tick); end
        end
        RESET_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_live();
        test_latched();
        test_counter();
        test_load_wrap();
        test_blink();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish exp finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
